// File: rtl/add_result_checker.sv
// Receive-side checker for the parity-predicted adder: verifies predicted parity,
// forwards clean words on valid/ready, requests bounded recomputes, flags sticky fault.
module add_result_checker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  input  logic             in_parout,
  input  logic             in_error,
  output logic             retry_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_par,
  output logic             fault,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    HOLD,
    RETRY,
    FAULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_s;
  logic             cap_cout;
  logic             cap_parout;
  logic             cap_error;
  logic [RC_W-1:0]  retry_cnt;
  logic             word_bad_c;

  // A word is bad when the received sum disagrees with its predicted parity
  // or the adder flagged an internal error.
  assign word_bad_c = ((^cap_s) != cap_parout) || cap_error;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      retry_req  <= 1'b0;
      out_valid  <= 1'b0;
      out_s      <= '0;
      out_cout   <= 1'b0;
      out_par    <= 1'b0;
      fault      <= 1'b0;
      err_count  <= '0;
      retry_cnt  <= '0;
      cap_s      <= '0;
      cap_cout   <= 1'b0;
      cap_parout <= 1'b0;
      cap_error  <= 1'b0;
    end else begin
      retry_req <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_s      <= in_s;
            cap_cout   <= in_cout;
            cap_parout <= in_parout;
            cap_error  <= in_error;
            in_ready   <= 1'b0;
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (word_bad_c) begin
            if (err_count != '1) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (retry_cnt < RC_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RC_W'(1);
              retry_req <= 1'b1;
              state     <= RETRY;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end else begin
            out_s     <= cap_s;
            out_cout  <= cap_cout;
            out_par   <= ^cap_s;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        RETRY: begin
          // retry_cnt survives so the re-presented word continues the budget
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            retry_cnt <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        FAULT: begin
          retry_cnt <= '0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/add_result_checker.md
# add_result_checker

Receiving end of the parity-predicted adder interface: captures each sum/carry word with its predicted parity and error flag, and checks the predicted parity against the parity of the received sum. Clean words pass downstream on a valid/ready handshake. Bad words trigger a bounded recompute request upstream, and repeated failure sets a sticky fault. It sits between the rc_pred adder datapath and the consumer of its results, and is the self-checking counterpart of the adder's parity predictor.

## Interface
- WIDTH, 3: sum width in bits.
- MAX_RETRY, 2: recompute requests allowed per word before declaring a fault.
- CNT_W, 8: width of the saturating error counter.

- clk_50  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream word present.
- in_ready  out  1  checker can accept a word.
- in_s  in  WIDTH  adder sum.
- in_cout  in  1  adder carry out.
- in_parout  in  1  predicted parity of in_s.
- in_error  in  1  adder internal error flag.
- retry_req  out  1  one-cycle pulse requesting upstream to recompute and re-present the word.
- out_valid  out  1  checked word available.
- out_ready  in  1  downstream accepts the word.
- out_s  out  WIDTH  registered checked sum.
- out_cout  out  1  registered checked carry.
- out_par  out  1  even parity of out_s, regenerated (^out_s).
- fault  out  1  sticky; retries exhausted on some word.
- err_count  out  CNT_W  saturating count of failed checks.

## Operation
- FSM states: IDLE, EVAL, HOLD, RETRY, FAULT. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid=1, the word (in_s, in_cout, in_parout, in_error) is captured and the FSM moves to EVAL.
- EVAL: the captured word is bad if (^s != parout) or error=1.
  - Good: move to HOLD and load out_s/out_cout.
  - Bad with retry_cnt < MAX_RETRY: retry_cnt+1, move to RETRY.
  - Bad with retry_cnt == MAX_RETRY: move to FAULT.
  - Every bad evaluation increments err_count, saturating at 2^CNT_W-1.
- RETRY: retry_req=1 for exactly this cycle, then return to IDLE to accept the re-presented word. retry_cnt is kept.
- HOLD: out_valid=1. out_s, out_cout and out_par stay stable until out_ready=1. On out_ready=1, retry_cnt clears and the FSM moves to IDLE.
- FAULT: fault is set and stays 1 until rst. The word is discarded, retry_cnt clears, and the FSM moves to IDLE. There is no out_valid for a discarded word.
- in_ready=1 only in IDLE. in_valid in any other state is ignored and nothing is captured.
- MAX_RETRY=0: the first bad word goes straight to FAULT and no retry_req is issued.

## Timing
- Reset values: in_ready=1; retry_req=0; out_valid=0; out_s=0; out_cout=0; out_par=0; fault=0; err_count=0. Internal retry_cnt=0.
- Accept at edge k. EVAL in cycle k→k+1. At edge k+1 the FSM enters HOLD, RETRY or FAULT.
- Good word: out_valid is high from edge k+1. Minimum input-to-output latency is 1 cycle after capture.
- Bad word: retry_req is high from edge k+1 to k+2, and in_ready is 1 again from edge k+2.
- Throughput: at most one word per 3 cycles with out_ready tied high (IDLE→EVAL→HOLD).
- out_ready=1 in a cycle where out_valid=0 has no effect.
- err_count and fault update at the same edge the FSM leaves EVAL.
- rst in any state returns to IDLE at the next edge with all reset values. Captured data, retry_cnt, fault and err_count are all cleared, and any pending output is dropped.

## Test plan
- Clean word: in_s=3'b101, in_cout=1, in_parout=0, in_error=0 → out_valid 1 cycle after accept; out_s=101, out_cout=1, out_par=0; err_count=0; no retry_req.
- Parity mismatch then good: in_s=101, in_parout=1 → single retry_req pulse and err_count=1. Re-present with in_parout=0 → out_s=101 delivered; fault=0.
- Retry exhaustion (MAX_RETRY=2): present in_s=011, in_parout=1 three times → exactly two retry_req pulses, then fault=1, err_count=3, no out_valid. Fault stays 1 across later good words.
- Adder error flag alone: in_s=110, in_parout=0 (parity correct), in_error=1 → treated as bad; retry_req pulses and err_count increments.
- Backpressure: good word with out_ready=0 for 5 cycles → out_valid and out_s held stable, in_ready=0, and a new in_valid during the hold is not captured. On out_ready=1 the FSM returns to IDLE the next cycle.
- Saturation and reset: CNT_W=2, MAX_RETRY=0, five bad words → err_count stays at 3. Assert rst during HOLD → next cycle out_valid=0, fault=0, err_count=0, in_ready=1.
